complex_dot_acc: RTL and testbench

Parametrised, fully pipelined complex multiply–accumulate engine for the matrix datapath. Each accepted beat carries `LANES` complex operand pairs. The block multiplies them lane-wise, with optional conjugation of `a`, and reduces the products through a registered adder tree. It then accumulates the tree sums over a variable number of beats until a `last` beat, which emits one complex dot-product result. It extends the fixed 16-lane single-shot matrix multiplier with lane count, data width, multi-beat accumulation, conjugate mode, overflow reporting and a global-stall valid/ready pipeline.

---
 rtl/complex_dot_acc.sv | 222 ++++++++++++++++++++++
 tb/tb_complex_dot_acc.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/complex_dot_acc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : complex_dot_acc                                              |
// | Description : Pipelined complex multiply-accumulate engine. Each beat      |
// |               carries LANES complex operand pairs; lane products (with     |
// |               optional conj(a)) are reduced by a registered adder tree and |
// |               accumulated across beats until a last beat emits one result. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module complex_dot_acc #(
  parameter int LANES     = 4,
  parameter int DATA_W    = 16,
  parameter int ACC_GUARD = 8,
  localparam int L        = $clog2(LANES),
  localparam int ACC_W    = 2*DATA_W + 1 + L + ACC_GUARD
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [LANES*DATA_W-1:0]  a_re_i,
  input  logic [LANES*DATA_W-1:0]  a_im_i,
  input  logic [LANES*DATA_W-1:0]  b_re_i,
  input  logic [LANES*DATA_W-1:0]  b_im_i,
  input  logic                     conj_i,
  input  logic                     last_i,
  input  logic                     flush_i,
  output logic [ACC_W-1:0]         result_re_o,
  output logic [ACC_W-1:0]         result_im_o,
  output logic                     overflow_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic                     busy_o
);

  // Full-precision lane product width and adder-tree output width.
  localparam int c_PROD_W = 2*DATA_W + 1;
  localparam int c_TREE_W = c_PROD_W + L;

  // Global advance enable: everything stalls while a result waits downstream.
  logic                w_en;
  logic [L:0]          w_stage_valid;

  logic [c_TREE_W-1:0] w_tree_re;
  logic [c_TREE_W-1:0] w_tree_im;
  logic                w_tree_valid;
  logic                w_tree_last;

  logic [ACC_W-1:0]    w_tree_ext_re;
  logic [ACC_W-1:0]    w_tree_ext_im;
  logic [ACC_W-1:0]    w_sum_re;
  logic [ACC_W-1:0]    w_sum_im;
  logic                w_ovf;

  logic [ACC_W-1:0]    r_acc_re;
  logic [ACC_W-1:0]    r_acc_im;
  logic                r_acc_ovf;
  logic                r_acc_active;
  logic [ACC_W-1:0]    r_res_re;
  logic [ACC_W-1:0]    r_res_im;
  logic                r_res_ovf;
  logic                r_out_valid;

  assign w_en = !(r_out_valid && !out_ready_i);

  genvar lv, k;

  // Level 0 is the product stage; levels 1..L are the pairwise adder tree.
  // Each level stores its nodes as one packed vector, c_W bits per node.
  for (lv = 0; lv <= L; lv++) begin : g_lvl
    localparam int c_N = LANES >> lv;
    localparam int c_W = c_PROD_W + lv;

    logic [c_N*c_W-1:0] r_re;
    logic [c_N*c_W-1:0] r_im;
    logic               r_valid;
    logic               r_last;

    assign w_stage_valid[lv] = r_valid;

    if (lv == 0) begin : g_prod
      logic [c_N*c_W-1:0] w_prod_re;
      logic [c_N*c_W-1:0] w_prod_im;

      // Operands are sign-extended to the product width first, so the low
      // c_W bits of each multiply are the exact signed product.
      for (k = 0; k < c_N; k++) begin : g_lane
        logic [c_W-1:0] w_ar, w_ai, w_br, w_bi;
        logic [c_W-1:0] w_rr, w_ii, w_ri, w_ir;

        assign w_ar = c_W'($signed(a_re_i[k*DATA_W +: DATA_W]));
        assign w_ai = c_W'($signed(a_im_i[k*DATA_W +: DATA_W]));
        assign w_br = c_W'($signed(b_re_i[k*DATA_W +: DATA_W]));
        assign w_bi = c_W'($signed(b_im_i[k*DATA_W +: DATA_W]));

        assign w_rr = w_ar * w_br;
        assign w_ii = w_ai * w_bi;
        assign w_ri = w_ar * w_bi;
        assign w_ir = w_ai * w_br;

        assign w_prod_re[k*c_W +: c_W] = conj_i ? (w_rr + w_ii) : (w_rr - w_ii);
        assign w_prod_im[k*c_W +: c_W] = conj_i ? (w_ri - w_ir) : (w_ri + w_ir);
      end

      // Register lane products with the beat's valid and last sideband.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          r_valid <= 1'b0;
          r_last  <= 1'b0;
          r_re    <= '0;
          r_im    <= '0;
        end else if (flush_i) begin
          r_valid <= 1'b0;
        end else if (w_en) begin
          r_valid <= in_valid_i;
          r_last  <= last_i;
          r_re    <= w_prod_re;
          r_im    <= w_prod_im;
        end
      end
    end else begin : g_add
      localparam int c_IW = c_W - 1;

      logic [c_N*c_W-1:0] w_add_re;
      logic [c_N*c_W-1:0] w_add_im;

      // Pairwise sums, each input sign-extended by one bit so no sum wraps.
      for (k = 0; k < c_N; k++) begin : g_node
        logic [c_IW-1:0] w_l_re, w_r_re, w_l_im, w_r_im;

        assign w_l_re = g_lvl[lv-1].r_re[(2*k)*c_IW   +: c_IW];
        assign w_r_re = g_lvl[lv-1].r_re[(2*k+1)*c_IW +: c_IW];
        assign w_l_im = g_lvl[lv-1].r_im[(2*k)*c_IW   +: c_IW];
        assign w_r_im = g_lvl[lv-1].r_im[(2*k+1)*c_IW +: c_IW];

        assign w_add_re[k*c_W +: c_W] = {w_l_re[c_IW-1], w_l_re} + {w_r_re[c_IW-1], w_r_re};
        assign w_add_im[k*c_W +: c_W] = {w_l_im[c_IW-1], w_l_im} + {w_r_im[c_IW-1], w_r_im};
      end

      // Register this tree level, carrying valid/last from the level above.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          r_valid <= 1'b0;
          r_last  <= 1'b0;
          r_re    <= '0;
          r_im    <= '0;
        end else if (flush_i) begin
          r_valid <= 1'b0;
        end else if (w_en) begin
          r_valid <= g_lvl[lv-1].r_valid;
          r_last  <= g_lvl[lv-1].r_last;
          r_re    <= w_add_re;
          r_im    <= w_add_im;
        end
      end
    end
  end

  assign w_tree_re    = g_lvl[L].r_re;
  assign w_tree_im    = g_lvl[L].r_im;
  assign w_tree_valid = g_lvl[L].r_valid;
  assign w_tree_last  = g_lvl[L].r_last;

  // Accumulator add wraps modulo 2^ACC_W; overflow is a same-sign operand
  // pair producing a sum of the opposite sign, on either component.
  assign w_tree_ext_re = ACC_W'($signed(w_tree_re));
  assign w_tree_ext_im = ACC_W'($signed(w_tree_im));
  assign w_sum_re      = r_acc_re + w_tree_ext_re;
  assign w_sum_im      = r_acc_im + w_tree_ext_im;
  assign w_ovf = ((r_acc_re[ACC_W-1] == w_tree_ext_re[ACC_W-1]) &&
                  (w_sum_re[ACC_W-1] != r_acc_re[ACC_W-1])) ||
                 ((r_acc_im[ACC_W-1] == w_tree_ext_im[ACC_W-1]) &&
                  (w_sum_im[ACC_W-1] != r_acc_im[ACC_W-1]));

  // Accumulate tree sums; a last beat moves the total into the output register
  // and restarts the accumulator, allowing back-to-back results.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_acc_re     <= '0;
      r_acc_im     <= '0;
      r_acc_ovf    <= 1'b0;
      r_acc_active <= 1'b0;
      r_res_re     <= '0;
      r_res_im     <= '0;
      r_res_ovf    <= 1'b0;
      r_out_valid  <= 1'b0;
    end else if (flush_i) begin
      r_acc_re     <= '0;
      r_acc_im     <= '0;
      r_acc_ovf    <= 1'b0;
      r_acc_active <= 1'b0;
      r_out_valid  <= 1'b0;
    end else if (w_en) begin
      r_out_valid <= w_tree_valid && w_tree_last;
      if (w_tree_valid) begin
        if (w_tree_last) begin
          r_res_re     <= w_sum_re;
          r_res_im     <= w_sum_im;
          r_res_ovf    <= r_acc_ovf | w_ovf;
          r_acc_re     <= '0;
          r_acc_im     <= '0;
          r_acc_ovf    <= 1'b0;
          r_acc_active <= 1'b0;
        end else begin
          r_acc_re     <= w_sum_re;
          r_acc_im     <= w_sum_im;
          r_acc_ovf    <= r_acc_ovf | w_ovf;
          r_acc_active <= 1'b1;
        end
      end
    end
  end

  assign in_ready_o  = w_en;
  assign result_re_o = r_res_re;
  assign result_im_o = r_res_im;
  assign overflow_o  = r_res_ovf;
  assign out_valid_o = r_out_valid;
  assign busy_o      = (|w_stage_valid) | r_acc_active | r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_complex_dot_acc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_complex_dot_acc                                           |
// | Description : Self-checking bench for complex_dot_acc: a table of one-beat |
// |               vectors plus directed multi-beat, stall, overflow, flush and |
// |               reset sequences. Two instances share stimulus: the default   |
// |               one (ACC_W=43) and one with ACC_GUARD=0 (ACC_W=35).          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_complex_dot_acc;

  localparam int LANES = 4;
  localparam int DW    = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic                  in_valid, conj, last, flush, out_ready;
  logic [LANES*DW-1:0]   a_re, a_im, b_re, b_im;

  logic                  in_ready, out_valid, ovf, busy;
  logic [42:0]           res_re, res_im;
  logic                  in_ready2, out_valid2, ovf2, busy2;
  logic [34:0]           res_re2, res_im2;

  int checks   = 0;
  int failures = 0;

  complex_dot_acc #(.LANES(LANES), .DATA_W(DW), .ACC_GUARD(8)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .a_re_i(a_re), .a_im_i(a_im), .b_re_i(b_re), .b_im_i(b_im),
    .conj_i(conj), .last_i(last), .flush_i(flush),
    .result_re_o(res_re), .result_im_o(res_im), .overflow_o(ovf),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .busy_o(busy)
  );

  complex_dot_acc #(.LANES(LANES), .DATA_W(DW), .ACC_GUARD(0)) dut2 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready2),
    .a_re_i(a_re), .a_im_i(a_im), .b_re_i(b_re), .b_im_i(b_im),
    .conj_i(conj), .last_i(last), .flush_i(flush),
    .result_re_o(res_re2), .result_im_o(res_im2), .overflow_o(ovf2),
    .out_valid_o(out_valid2), .out_ready_i(out_ready), .busy_o(busy2)
  );

  typedef struct {
    logic [15:0] ar, ai, br, bi;
    logic        cj;
    longint      er, ei;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic signed [63:0] act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic [15:0] ar, ai, br, bi, input logic cj, lst);
    a_re     = {LANES{ar}};
    a_im     = {LANES{ai}};
    b_re     = {LANES{br}};
    b_im     = {LANES{bi}};
    conj     = cj;
    last     = lst;
    in_valid = 1'b1;
  endtask

  // Waits (bounded) for a result on the default instance and checks it.
  task automatic wait_result(input string name, input longint er, ei, input longint eovf, input longint lat);
    int cnt = 0;
    while (!out_valid && cnt < 20) begin
      tick;
      cnt++;
    end
    check({name, " latency"}, 64'(cnt), lat);
    check({name, " re"}, 64'($signed(res_re)), er);
    check({name, " im"}, 64'($signed(res_im)), ei);
    check({name, " ovf"}, 64'(ovf), eovf);
  endtask

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    logic seen;
    in_valid = 1'b0; conj = 1'b0; last = 1'b0; flush = 1'b0; out_ready = 1'b1;
    a_re = '0; a_im = '0; b_re = '0; b_im = '0;

    tbl[0] = '{16'd1,    16'd2,    16'd3,    16'd4,    1'b0, -20,  40};
    tbl[1] = '{16'd1,    16'd2,    16'd3,    16'd4,    1'b1,  44,  -8};
    tbl[2] = '{16'd0,    16'd0,    16'd0,    16'd0,    1'b0,   0,   0};
    tbl[3] = '{16'hFFFF, 16'd0,    16'd5,    16'd0,    1'b0, -20,   0};
    tbl[4] = '{16'd100,  16'hFFFD, 16'd7,    16'd9,    1'b0, 2908, 3516};
    tbl[5] = '{16'd100,  16'hFFFD, 16'd7,    16'd9,    1'b1, 2692, 3684};
    tbl[6] = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 1'b0, 0, 64'sd8589934592};
    tbl[7] = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 1'b1, 64'sd8589934592, 0};

    // Reset state
    #1 rst = 1'b1;
    #10;
    check("rst in_ready", 64'(in_ready), 1);
    check("rst out_valid", 64'(out_valid), 0);
    check("rst res_re", 64'($signed(res_re)), 0);
    check("rst res_im", 64'($signed(res_im)), 0);
    check("rst ovf", 64'(ovf), 0);
    check("rst busy", 64'(busy), 0);
    @(negedge clk) rst = 1'b0;
    tick;

    // One-beat vectors from the table, on both instances
    for (int i = 0; i < 8; i++) begin
      set_beat(tbl[i].ar, tbl[i].ai, tbl[i].br, tbl[i].bi, tbl[i].cj, 1'b1);
      tick;
      in_valid = 1'b0;
      wait_result($sformatf("vec%0d", i), tbl[i].er, tbl[i].ei, 0, 3);
      check($sformatf("vec%0d re2", i), 64'($signed(res_re2)), tbl[i].er);
      check($sformatf("vec%0d im2", i), 64'($signed(res_im2)), tbl[i].ei);
      tick;
      check($sformatf("vec%0d busy after", i), 64'(busy), 0);
      check($sformatf("vec%0d out_valid after", i), 64'(out_valid), 0);
    end

    // Distinct lanes: a_k = (k+1) - k j, b = 2 + 1j  ->  26 - 2j
    set_beat(16'd0, 16'd0, 16'd2, 16'd1, 1'b0, 1'b1);
    a_re = {16'd4, 16'd3, 16'd2, 16'd1};
    a_im = {16'hFFFD, 16'hFFFE, 16'hFFFF, 16'h0000};
    tick;
    in_valid = 1'b0;
    wait_result("lanes", 26, -2, 0, 3);
    tick;

    // Mixed-conj two-beat vector
    set_beat(16'd1, 16'd2, 16'd3, 16'd4, 1'b0, 1'b0);
    tick;
    set_beat(16'd1, 16'd2, 16'd3, 16'd4, 1'b1, 1'b1);
    tick;
    in_valid = 1'b0;
    wait_result("mixed", 24, 32, 0, 3);
    tick;

    // Stall: 3-beat vector, downstream blocked while the next vector streams in
    out_ready = 1'b0;
    set_beat(16'd1, 16'd2, 16'd3, 16'd4, 1'b0, 1'b0);
    tick;
    tick;
    last = 1'b1;
    tick;
    set_beat(16'd1, 16'd2, 16'd3, 16'd4, 1'b1, 1'b0);
    tick;
    tick;
    tick;
    last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall%0d out_valid", i), 64'(out_valid), 1);
      check($sformatf("stall%0d re", i), 64'($signed(res_re)), -60);
      check($sformatf("stall%0d im", i), 64'($signed(res_im)), 120);
      check($sformatf("stall%0d in_ready", i), 64'(in_ready), 0);
      if (i < 4) tick;
    end
    out_ready = 1'b1;
    tick;
    in_valid = 1'b0;
    check("stall drop out_valid", 64'(out_valid), 0);
    wait_result("after stall", 176, -32, 0, 3);
    tick;

    // Accumulator overflow on the ACC_GUARD=0 instance
    set_beat(16'h8000, 16'h7FFF, 16'h8000, 16'h8000, 1'b0, 1'b0);
    tick;
    tick;
    last = 1'b1;
    tick;
    in_valid = 1'b0;
    wait_result("wide no-ovf", 64'sd25769410560, 393216, 0, 3);
    check("narrow ovf", 64'(ovf2), 1);
    check("narrow ovf re", 64'($signed(res_re2)), -64'sd8590327808);
    check("narrow ovf im", 64'($signed(res_im2)), 393216);
    tick;
    set_beat(16'd1, 16'd2, 16'd3, 16'd4, 1'b0, 1'b1);
    tick;
    in_valid = 1'b0;
    wait_result("clean after ovf", -20, 40, 0, 3);
    check("narrow clean ovf", 64'(ovf2), 0);
    check("narrow clean re", 64'($signed(res_re2)), -20);
    tick;

    // Flush: two accumulated beats and the beat presented with flush are dropped
    set_beat(16'd7, 16'd0, 16'd1, 16'd0, 1'b0, 1'b0);
    tick;
    tick;
    in_valid = 1'b0;
    tick;
    tick;
    tick;
    check("preflush busy", 64'(busy), 1);
    flush = 1'b1;
    set_beat(16'd9, 16'd0, 16'd1, 16'd0, 1'b0, 1'b1);
    tick;
    flush = 1'b0;
    in_valid = 1'b0;
    check("postflush busy", 64'(busy), 0);
    check("postflush in_ready", 64'(in_ready), 1);
    check("postflush out_valid", 64'(out_valid), 0);
    set_beat(16'd1, 16'd2, 16'd3, 16'd4, 1'b0, 1'b1);
    tick;
    in_valid = 1'b0;
    wait_result("after flush", -20, 40, 0, 3);
    tick;

    // Back-to-back one-beat vectors, then asynchronous reset mid-stream
    for (int k = 1; k <= 6; k++) begin
      set_beat(16'(k), 16'd0, 16'd1, 16'd0, 1'b0, 1'b1);
      tick;
      if (k >= 4) begin
        check($sformatf("b2b%0d out_valid", k - 3), 64'(out_valid), 1);
        check($sformatf("b2b%0d re", k - 3), 64'($signed(res_re)), 4 * (k - 3));
      end
    end
    in_valid = 1'b0;
    tick;
    check("b2b4 out_valid", 64'(out_valid), 1);
    check("b2b4 re", 64'($signed(res_re)), 16);
    #2 rst = 1'b1;
    #1;
    check("async rst out_valid", 64'(out_valid), 0);
    check("async rst res_re", 64'($signed(res_re)), 0);
    check("async rst res_im", 64'($signed(res_im)), 0);
    check("async rst ovf", 64'(ovf), 0);
    check("async rst busy", 64'(busy), 0);
    check("async rst in_ready", 64'(in_ready), 1);
    @(negedge clk) rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick;
      seen = seen | out_valid | busy;
    end
    check("no stale after rst", 64'(seen), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
